// File: rtl/imgram_rect_fill.sv
// Rectangle-fill engine for the imgram frame buffer: writes one solid or outlined
// rectangle per command, one pixel per clock in row-major order, through port A.
module imgram_rect_fill #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [9:0]         rect_x,
  input  logic [8:0]         rect_y,
  input  logic [9:0]         rect_w,
  input  logic [8:0]         rect_h,
  input  logic [COLOR_W-1:0] color,
  input  logic               outline,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  addr_imgmem,
  output logic [COLOR_W-1:0] data_imgmem,
  output logic               wren_imgmem
);

  // state  | meaning
  // IDLE   | waiting for start; command latched on acceptance
  // FILL   | presenting one pixel per cycle, row-major
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [10:0]       H_LIM  = 11'(H_RES);
  localparam logic [9:0]        V_LIM  = 10'(V_RES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  state_t               state_q, state_d;
  logic [9:0]           x_q, x_d;
  logic [9:0]           w_q, w_d;
  logic [8:0]           h_q, h_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 outline_q, outline_d;
  logic [9:0]           i_q, i_d;
  logic [8:0]           j_q, j_d;
  logic [10:0]          cx_q, cx_d;
  logic [9:0]           cy_q, cy_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wren_q, wren_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COLOR_W-1:0]   data_q, data_d;
  logic                 pix_vld;
  logic                 on_edge;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      outline_q <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      base_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      w_q       <= w_d;
      h_q       <= h_d;
      color_q   <= color_d;
      outline_q <= outline_d;
      i_q       <= i_d;
      j_q       <= j_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      base_q    <= base_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // The _d counters describe the pixel presented in the next cycle, so every
  // port-A output can be registered without adding latency.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    outline_d = outline_q;
    i_d       = i_q;
    j_d       = j_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    base_d    = base_q;
    pix_vld   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = rect_x;
          w_d       = rect_w;
          h_d       = rect_h;
          color_d   = color;
          outline_d = outline;
          if (rect_w != 10'd0 && rect_h != 9'd0) begin
            state_d = S_FILL;
            i_d     = '0;
            j_d     = '0;
            cx_d    = {1'b0, rect_x};
            cy_d    = {1'b0, rect_y};
            // One constant multiply per command; pixels only add.
            base_d  = ADDR_W'(rect_y) * H_STEP;
            pix_vld = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FILL: begin
        if (i_q == w_q - 10'd1) begin
          if (j_q == h_q - 9'd1) begin
            state_d = S_DONE;
          end else begin
            i_d     = '0;
            j_d     = j_q + 9'd1;
            cx_d    = {1'b0, x_q};
            cy_d    = cy_q + 10'd1;
            base_d  = base_q + H_STEP;
            pix_vld = 1'b1;
          end
        end else begin
          i_d     = i_q + 10'd1;
          cx_d    = cx_q + 11'd1;
          pix_vld = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    on_edge = (i_d == 10'd0) || (i_d == w_d - 10'd1) ||
              (j_d == 9'd0)  || (j_d == h_d - 9'd1);
    wren_d  = pix_vld && (cx_d < H_LIM) && (cy_d < V_LIM) && (!outline_d || on_edge);
    addr_d  = wren_d ? (base_d + ADDR_W'(cx_d)) : '0;
    data_d  = wren_d ? color_d : '0;
    busy_d  = (state_d == S_FILL);
    done_d  = (state_d == S_DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wren_imgmem = wren_q;
  assign addr_imgmem = addr_q;
  assign data_imgmem = data_q;

endmodule

// File: tb/tb_imgram_rect_fill.sv
// Scoreboard bench for imgram_rect_fill: each command pushes its expected per-cycle
// port-A/handshake trace; a negedge monitor pops and compares.
module tb_imgram_rect_fill;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  rect_x;
  logic [8:0]  rect_y;
  logic [9:0]  rect_w;
  logic [8:0]  rect_h;
  logic [7:0]  color;
  logic        outline;
  logic        busy;
  logic        done;
  logic [18:0] addr_imgmem;
  logic [7:0]  data_imgmem;
  logic        wren_imgmem;

  imgram_rect_fill #(.H_RES(640), .V_RES(480), .ADDR_W(19), .COLOR_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .color       (color),
    .outline     (outline),
    .busy        (busy),
    .done        (done),
    .addr_imgmem (addr_imgmem),
    .data_imgmem (data_imgmem),
    .wren_imgmem (wren_imgmem)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wren;
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("wren", 32'(wren_imgmem), 32'(e.wren));
        if (e.wren) begin
          chk("addr", 32'(addr_imgmem), 32'(e.addr));
          chk("data", 32'(data_imgmem), 32'(e.data));
        end
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_wren", 32'(wren_imgmem), 32'd0);
      end
    end
  end

  task automatic push_idle();
    exp_q.push_back('{busy: 1'b0, done: 1'b0, wren: 1'b0, addr: '0, data: '0});
  endtask

  task automatic push_model(input int x, input int y, input int w, input int h,
                            input logic [7:0] c, input bit ol);
    int  cx, cy;
    bit  wr;
    if (w != 0 && h != 0) begin
      for (int j = 0; j < h; j++) begin
        for (int i = 0; i < w; i++) begin
          cx = x + i;
          cy = y + j;
          wr = (cx < 640) && (cy < 480) &&
               (!ol || i == 0 || i == w - 1 || j == 0 || j == h - 1);
          exp_q.push_back('{busy: 1'b1, done: 1'b0, wren: wr,
                            addr: wr ? 19'(cy * 640 + cx) : 19'd0,
                            data: wr ? c : 8'd0});
        end
      end
    end
    exp_q.push_back('{busy: 1'b0, done: 1'b1, wren: 1'b0, addr: '0, data: '0});
  endtask

  // Returns one ns after the accepting edge; inputs are scrambled afterwards.
  task automatic drive_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] c, input bit ol);
    @(posedge clock);
    #1;
    rect_x  = 10'(x);
    rect_y  = 9'(y);
    rect_w  = 10'(w);
    rect_h  = 9'(h);
    color   = c;
    outline = ol;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    rect_x  = 10'($urandom);
    rect_y  = 9'($urandom);
    rect_w  = 10'($urandom);
    rect_h  = 9'($urandom);
    color   = 8'($urandom);
    outline = 1'($urandom);
    push_model(x, y, w, h, c, ol);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    rect_x  = '0;
    rect_y  = '0;
    rect_w  = '0;
    rect_h  = '0;
    color   = '0;
    outline = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wren", 32'(wren_imgmem), 32'd0);
    chk("rst_addr", 32'(addr_imgmem), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    mon_en = 1'b1;

    // solid 2x2, zero width, corner clip, 3x3 outline
    drive_cmd(10, 5, 2, 2, 8'h1C, 1'b0);
    wait_drain(20);
    drive_cmd(3, 3, 0, 7, 8'h55, 1'b0);
    wait_drain(20);
    drive_cmd(639, 479, 2, 2, 8'hA7, 1'b0);
    wait_drain(20);
    drive_cmd(0, 0, 3, 3, 8'h3E, 1'b1);
    wait_drain(30);

    // start during busy is dropped; start held through DONE is taken in next IDLE
    drive_cmd(100, 20, 4, 1, 8'h33, 1'b0);
    push_idle();
    push_model(200, 30, 2, 1, 8'h44, 1'b0);
    @(posedge clock);
    #1;
    rect_x  = 10'd200;
    rect_y  = 9'd30;
    rect_w  = 10'd2;
    rect_h  = 9'd1;
    color   = 8'h44;
    outline = 1'b0;
    start   = 1'b1;
    repeat (5) @(posedge clock);
    #1 start = 1'b0;
    wait_drain(30);

    // a few random rectangles straddling the frame edges
    for (int t = 0; t < 4; t++) begin
      drive_cmd(int'($urandom_range(630, 645)), int'($urandom_range(470, 485)),
                int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                8'($urandom), 1'($urandom));
      wait_drain(60);
    end

    // async reset during pixel 3 of a 10x10 fill
    drive_cmd(50, 50, 10, 10, 8'hC3, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    mon_en = 1'b0;
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(wren_imgmem), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(addr_imgmem), 32'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clock);
    drive_cmd(20, 1, 3, 2, 8'h5A, 1'b1);
    wait_drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imgram_rect_fill.md
# imgram_rect_fill

Hardware rectangle-fill engine that writes solid or outlined rectangles into the frame-buffer image RAM (`imgram`) through its processor-side port A. The VGA controller reads the same RAM on port B; this block is the pixel writer for that path. It offloads per-pixel stores from the processor: one command draws one rectangle, e.g. a Tetris cell, board border or screen clear. It writes one pixel per clock in row-major order, with a start/busy/done handshake.

## Interface
Parameters:
- `H_RES`, 640: frame width in pixels.
- `V_RES`, 480: frame height in pixels.
- `ADDR_W`, 19: imgram address width.
- `COLOR_W`, 8: pixel colour-index width.

Ports:
- `clock`  in  1  sole clock. imgram port A is clocked on `~clock`, so a write issued here lands in the same cycle.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `rect_x`  in  10  left column of the rectangle.
- `rect_y`  in  9  top row of the rectangle.
- `rect_w`  in  10  width in pixels.
- `rect_h`  in  9  height in pixels.
- `color`  in  COLOR_W  fill colour index.
- `outline`  in  1  1 = write border pixels only. 0 = solid fill.
- `busy`  out  1  high while a command is executing.
- `done`  out  1  one-cycle completion pulse.
- `addr_imgmem`  out  ADDR_W  imgram port-A address.
- `data_imgmem`  out  COLOR_W  imgram port-A write data.
- `wren_imgmem`  out  1  imgram port-A write enable.

## Operation
- States are IDLE, FILL and DONE.
- **IDLE:** if `start`=1, latch `rect_x/y/w/h`, `color` and `outline`. Go to FILL if w≠0 and h≠0, otherwise go to DONE.
- **FILL:** counters `i` (column, 0..w-1) and `j` (row, 0..h-1) step row-major, one pixel per cycle.
  - When `i`=w-1, set `i`←0 and `j`←j+1.
  - After pixel (w-1, h-1), go to DONE.
- **DONE:** assert `done` for one cycle, then go to IDLE.
- **Pixel coordinates:** `cx`=rect_x+i (11-bit), `cy`=rect_y+j (10-bit). No wrap is allowed.
- **Write condition:** a write requires `cx`<H_RES and `cy`<V_RES. In outline mode it also requires i=0, i=w-1, j=0 or j=h-1.
- **Skipped pixels:** a pixel that fails the write condition (clipped, or interior in outline mode) still consumes its cycle with `wren_imgmem`=0.
- **Address:** `addr_imgmem` = cy·H_RES + cx. Keep a row base that starts at rect_y·H_RES and adds H_RES per row. No multiplier on the per-pixel path.
- **Data:** `data_imgmem` = latched colour whenever `wren_imgmem`=1.
- **`start` while busy:** ignored, with no queueing. `start` held high through DONE is re-accepted in the next IDLE cycle.
- **Latched command:** input changes after acceptance have no effect.

## Timing
- Command accepted at edge T (IDLE, `start`=1).
- `busy`=1 from T+1 through the final FILL cycle. `busy`=0 in IDLE and DONE.
- Pixel k (0-based, row-major) is presented on the imgram outputs in cycle T+1+k. All three outputs are registered.
- `done`=1 in cycle T+1+w·h, for exactly one cycle. A zero-size command gives `done` at T+1 with no writes.
- Maximum throughput: one new command every w·h+2 cycles.
- **Reset:** `reset_n`=0 forces the following immediately, including mid-FILL with no further writes.
  - State IDLE.
  - `busy`=0 and `done`=0.
  - `wren_imgmem`=0, `addr_imgmem`=0 and `data_imgmem`=0.

## Test plan
- **Solid 2×2:** rect (10,5), colour 0x1C, accepted at T. Required:
  - writes to 3210, 3211, 3850, 3851 at T+1..T+4, each with data 0x1C;
  - `busy` high T+1..T+4;
  - `done` pulse at T+5.
- **Zero width:** w=0, h=7. Required: no `wren_imgmem` ever; `busy` never high; `done` at T+1.
- **Clipping:** 2×2 at (639,479). Required:
  - a single write to 307199 at T+1;
  - `wren_imgmem`=0 at T+2..T+4;
  - `done` at T+5.
- **Outline 3×3:** at (0,0). Required:
  - writes at 0, 1, 2, 640, 642, 1280, 1281, 1282;
  - no write to 641 (T+5 has `wren_imgmem`=0);
  - `done` at T+10.
- **Start while busy:** second `start` at T+2 of a 4×1 fill. Required: it is ignored and exactly 4 writes occur. Then hold `start` through DONE. Required: the new command is accepted in the following IDLE cycle.
- **Reset mid-fill:** pull `reset_n` low asynchronously during pixel 3 of a 10×10 fill. Required:
  - `wren_imgmem`, `busy`, `done` and `addr_imgmem` are 0 immediately;
  - after release, the block is IDLE and accepts a new command normally.
